// File: rtl/freq_meter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : freq_meter_pkg
//  Description : Shared types and helpers for the frequency meter.
//                - state_t : measurement FSM states
//                - BCD_W   : bits per BCD digit
//                - clog2   : ceiling log2 used to size internal counters
//  Revision    : 1.0  initial release
// ============================================================================
package freq_meter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WARMUP = 2'd1,
      GATE   = 2'd2
   } state_t;

   localparam int BCD_W = 4;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit
//  Description : One BCD digit of the edge-counting chain.
//  Ports       : sysclk  in   clock
//                rst     in   asynchronous reset, active high
//                inc     in   increment request (ripple input)
//                hold    in   chain is saturated: suppress the increment
//                clr     in   synchronous clear (wins over increment)
//                digit   out  current digit value
//                incd    out  value after this cycle's increment, before clr
//                carry   out  inc & (digit == 9)
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_digit
   import freq_meter_pkg::*;
(
   input  logic             sysclk,
   input  logic             rst,
   input  logic             inc,
   input  logic             hold,
   input  logic             clr,
   output logic [BCD_W-1:0] digit,
   output logic [BCD_W-1:0] incd,
   output logic             carry
);

   logic [BCD_W-1:0] r_digit;
   logic             w_nine;
   logic             w_step;

   assign w_nine = (r_digit == BCD_W'(9));
   assign w_step = inc & ~hold;
   assign carry  = inc & w_nine;
   assign incd   = w_step ? (w_nine ? '0 : r_digit + BCD_W'(1)) : r_digit;
   assign digit  = r_digit;

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         r_digit <= '0;
      end else if (clr) begin
         r_digit <= '0;
      end else begin
         r_digit <= incd;
      end
   end

endmodule
`default_nettype wire

// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
//  Module      : freq_meter
//  Description : Counts rising edges of the asynchronous input sigin over a
//                fixed gate window of GATE_CYCLES sysclk cycles in a BCD
//                chain; at each window end the count is latched as the
//                reading and freq_valid pulses. Windows run back to back.
//  Ports       : sysclk      in   system clock (rising edge)
//                rst         in   asynchronous reset, active high
//                enable      in   1 = measure continuously, 0 = idle
//                sigin       in   asynchronous signal under test
//                freq_bcd    out  last completed reading, digit 0 in [3:0]
//                freq_valid  out  one-cycle pulse when freq_bcd/overflow update
//                overflow    out  last reading saturated at all nines
//                measuring   out  high while a gate window is open
//  Revision    : 1.0  initial release
// ============================================================================
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int CLK_HZ      = 50_000_000,
   parameter int GATE_CYCLES = CLK_HZ,
   parameter int DIGITS      = 5,
   parameter int SYNC_STAGES = 2
) (
   input  logic                      sysclk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic                      sigin,
   output logic [BCD_W*DIGITS-1:0]   freq_bcd,
   output logic                      freq_valid,
   output logic                      overflow,
   output logic                      measuring
);

   localparam int c_gate_w = (clog2(GATE_CYCLES) > 0) ? clog2(GATE_CYCLES) : 1;
   localparam int c_warm_w = (clog2(SYNC_STAGES + 1) > 0) ? clog2(SYNC_STAGES + 1) : 1;
   localparam logic [c_gate_w-1:0] c_gate_last = c_gate_w'(GATE_CYCLES - 1);
   localparam logic [c_warm_w-1:0] c_warm_last = c_warm_w'(SYNC_STAGES);

   if (CLK_HZ < 1 || GATE_CYCLES < 1 || DIGITS < 1 || SYNC_STAGES < 2) begin : g_param_check
      $error("freq_meter: invalid parameter set");
   end

   // ---------------------------------------------------------------- sync
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_hist;
   logic                   w_edge;

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
         r_hist <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], sigin};
         r_hist <= r_sync[SYNC_STAGES-1];
      end
   end

   assign w_edge = r_sync[SYNC_STAGES-1] & ~r_hist;

   // ----------------------------------------------------------- BCD chain
   state_t                  r_state;
   logic [c_gate_w-1:0]     r_gate_cnt;
   logic [c_warm_w-1:0]     r_warm_cnt;
   logic                    r_sticky;
   logic [BCD_W*DIGITS-1:0] r_freq;
   logic                    r_valid;
   logic                    r_ovf;
   logic                    r_meas;

   logic                    w_count;
   logic                    w_gate_end;
   logic                    w_chain_clr;
   logic                    w_sat;
   logic                    w_prefix;
   logic [DIGITS-1:0]       w_inc;
   logic [DIGITS-1:0]       w_carry;
   logic [DIGITS-1:0]       w_nine;
   logic [BCD_W*DIGITS-1:0] w_chain;
   logic [BCD_W*DIGITS-1:0] w_chain_next;

   assign w_count     = (r_state == GATE) & w_edge;
   assign w_gate_end  = (r_state == GATE) && (r_gate_cnt == c_gate_last);
   // Chain is held at zero outside GATE, so it is clean on WARMUP entry;
   // at window end it clears while the reading takes w_chain_next.
   assign w_chain_clr = (r_state != GATE) | w_gate_end;
   // Every carry set means all digits are 9 and an edge arrived.
   assign w_sat       = &w_carry;

   // Increment requests come from the registered nine flags of the lower
   // digits, so the whole chain settles in one cycle without a
   // combinational path through the digits' carry outputs.
   always_comb begin
      w_prefix = 1'b1;
      w_inc    = '0;
      for (int i = 0; i < DIGITS; i++) begin
         w_inc[i] = w_count & w_prefix;
         w_prefix = w_prefix & w_nine[i];
      end
   end

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit u_digit (
         .sysclk (sysclk),
         .rst    (rst),
         .inc    (w_inc[i]),
         .hold   (w_sat),
         .clr    (w_chain_clr),
         .digit  (w_chain[i*BCD_W +: BCD_W]),
         .incd   (w_chain_next[i*BCD_W +: BCD_W]),
         .carry  (w_carry[i])
      );
      assign w_nine[i] = (w_chain[i*BCD_W +: BCD_W] == BCD_W'(9));
   end

   // ----------------------------------------------------------------- FSM
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_gate_cnt <= '0;
         r_warm_cnt <= '0;
         r_sticky   <= 1'b0;
         r_freq     <= '0;
         r_valid    <= 1'b0;
         r_ovf      <= 1'b0;
         r_meas     <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               r_meas     <= 1'b0;
               r_gate_cnt <= '0;
               r_warm_cnt <= '0;
               r_sticky   <= 1'b0;
               if (enable) r_state <= WARMUP;
            end
            // Lets stale synchronizer contents flush out before counting.
            WARMUP: begin
               if (!enable) begin
                  r_state <= IDLE;
               end else if (r_warm_cnt == c_warm_last) begin
                  r_state    <= GATE;
                  r_meas     <= 1'b1;
                  r_gate_cnt <= '0;
                  r_sticky   <= 1'b0;
               end else begin
                  r_warm_cnt <= r_warm_cnt + c_warm_w'(1);
               end
            end
            GATE: begin
               if (w_gate_end) begin
                  // Terminal cycle always reports, even if enable dropped.
                  r_freq     <= w_chain_next;
                  r_ovf      <= r_sticky | w_sat;
                  r_valid    <= 1'b1;
                  r_sticky   <= 1'b0;
                  r_gate_cnt <= '0;
                  if (!enable) begin
                     r_state <= IDLE;
                     r_meas  <= 1'b0;
                  end
               end else if (!enable) begin
                  r_state <= IDLE;
                  r_meas  <= 1'b0;
               end else begin
                  r_gate_cnt <= r_gate_cnt + c_gate_w'(1);
                  if (w_sat) r_sticky <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_meas  <= 1'b0;
            end
         endcase
      end
   end

   assign freq_bcd   = r_freq;
   assign freq_valid = r_valid;
   assign overflow   = r_ovf;
   assign measuring  = r_meas;

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_freq_meter
//  Description : Scoreboard bench for freq_meter. Two instances share clock,
//                reset and sigin: a 5-digit meter and a 2-digit meter used
//                for saturation. Stimulus pushes hand-computed readings with
//                the cycle they must appear on; monitors pop on freq_valid.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_freq_meter;

   typedef struct {
      logic [19:0] bcd;
      logic        ovf;
      int          at;
   } exp_t;

   logic        sysclk = 1'b0;
   logic        rst;
   logic        en5;
   logic        en2;
   logic        sigin;
   logic [19:0] freq_bcd5;
   logic        freq_valid5;
   logic        overflow5;
   logic        measuring5;
   logic [7:0]  freq_bcd2;
   logic        freq_valid2;
   logic        overflow2;
   logic        measuring2;

   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   per;
   int   ph;
   int   k;
   int   t;
   exp_t q5[$];
   exp_t q2[$];
   exp_t e5;
   exp_t e2;

   always #5 sysclk = ~sysclk;
   always @(posedge sysclk) cyc <= cyc + 1;

   freq_meter #(.CLK_HZ(1000), .GATE_CYCLES(1000), .DIGITS(5), .SYNC_STAGES(2)) u_dut5 (
      .sysclk(sysclk), .rst(rst), .enable(en5), .sigin(sigin),
      .freq_bcd(freq_bcd5), .freq_valid(freq_valid5), .overflow(overflow5), .measuring(measuring5)
   );

   freq_meter #(.CLK_HZ(1000), .GATE_CYCLES(1000), .DIGITS(2), .SYNC_STAGES(2)) u_dut2 (
      .sysclk(sysclk), .rst(rst), .enable(en2), .sigin(sigin),
      .freq_bcd(freq_bcd2), .freq_valid(freq_valid2), .overflow(overflow2), .measuring(measuring2)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ------------------------------------------------------------ monitors
   always @(negedge sysclk) begin
      if (freq_valid5) begin
         if (q5.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL valid5: got freq_valid at cycle %0d, required none", cyc);
         end else begin
            e5 = q5.pop_front();
            chk("bcd5", int'(freq_bcd5), int'(e5.bcd));
            chk("ovf5", int'(overflow5), int'(e5.ovf));
            chk("time5", cyc, e5.at);
         end
      end
   end

   always @(negedge sysclk) begin
      if (freq_valid2) begin
         if (q2.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL valid2: got freq_valid at cycle %0d, required none", cyc);
         end else begin
            e2 = q2.pop_front();
            chk("bcd2", int'(freq_bcd2), int'(e2.bcd[7:0]));
            chk("ovf2", int'(overflow2), int'(e2.ovf));
            chk("time2", cyc, e2.at);
         end
      end
   end

   // ------------------------------------------------------------ stimulus
   task automatic push5(input int bcd, input bit ovf, input int at);
      exp_t e;
      e.bcd = bcd[19:0];
      e.ovf = ovf;
      e.at  = at;
      q5.push_back(e);
   endtask

   task automatic push2(input int bcd, input bit ovf, input int at);
      exp_t e;
      e.bcd = bcd[19:0];
      e.ovf = ovf;
      e.at  = at;
      q2.push_back(e);
   endtask

   // One negedge; sigin follows a square wave of period per when per != 0.
   task automatic tick();
      @(negedge sysclk);
      if (per != 0) begin
         sigin = (ph < per / 2);
         ph    = (ph + 1) % per;
      end
   endtask

   task automatic run_to(input int target);
      while (cyc < target) tick();
   endtask

   // Idle both meters, then start sigin rising at cycle kk and enable one meter.
   task automatic start(input int p, input bit use2, output int kk);
      en5   = 1'b0;
      en2   = 1'b0;
      per   = 0;
      sigin = 1'b0;
      repeat (4) tick();
      per = p;
      ph  = 0;
      tick();
      kk = cyc;
      if (use2) en2 = 1'b1;
      else      en5 = 1'b1;
   endtask

   initial begin
      rst   = 1'b1;
      en5   = 1'b0;
      en2   = 1'b0;
      sigin = 1'b0;
      per   = 0;
      ph    = 0;
      repeat (3) tick();
      chk("rst_bcd5", int'(freq_bcd5), 0);
      chk("rst_valid5", int'(freq_valid5), 0);
      chk("rst_ovf5", int'(overflow5), 0);
      chk("rst_meas5", int'(measuring5), 0);
      chk("rst_bcd2", int'(freq_bcd2), 0);

      // Period 40 from reset release: 25 edges per 1000-cycle window.
      per = 40;
      ph  = 0;
      tick();
      k   = cyc;
      rst = 1'b0;
      en5 = 1'b1;
      for (int w = 0; w < 3; w++) push5('h25, 1'b0, k + 1004 + 1000 * w);
      run_to(k + 500);
      chk("meas_open", int'(measuring5), 1);
      run_to(k + 3010);
      en5 = 1'b0;

      // Period 20, switching to period 8 at offset 2500 inside window 3.
      start(20, 1'b0, k);
      push5('h50, 1'b0, k + 1004);
      push5('h50, 1'b0, k + 2004);
      push5('h87, 1'b0, k + 3004);
      push5('h125, 1'b0, k + 4004);
      run_to(k + 2499);
      per = 8;
      ph  = 0;
      tick();
      run_to(k + 4010);
      en5 = 1'b0;

      // Enable dropped at gate_cnt 500 of window 2, then re-enabled.
      start(40, 1'b0, k);
      push5('h25, 1'b0, k + 1004);
      run_to(k + 1504);
      chk("meas_before_drop", int'(measuring5), 1);
      en5 = 1'b0;
      tick();
      chk("meas_after_drop", int'(measuring5), 0);
      chk("bcd_kept", int'(freq_bcd5), 'h25);
      run_to(k + 1800);
      en5 = 1'b1;
      k   = cyc;
      push5('h25, 1'b0, k + 1004);
      run_to(k + 1010);
      en5 = 1'b0;

      // Single pulses; the one at offset 1001 lands on gate_cnt 999.
      // Enable drops in the terminal cycle of window 3.
      start(0, 1'b0, k);
      push5('h2, 1'b0, k + 1004);
      push5('h2, 1'b0, k + 2004);
      push5('h1, 1'b0, k + 3004);
      while (cyc < k + 3003) begin
         tick();
         t     = cyc - k;
         sigin = (t == 500) || (t == 1001) || (t == 1010) || (t == 2000) || (t == 2002);
      end
      en5 = 1'b0;
      tick();
      chk("meas_after_last", int'(measuring5), 0);

      // Two-digit meter: period 4 saturates, then period 40 reads 25.
      start(4, 1'b1, k);
      push2('h99, 1'b1, k + 1004);
      push2('h25, 1'b0, k + 2004);
      run_to(k + 1003);
      per = 40;
      ph  = 0;
      tick();
      run_to(k + 2004);
      en2 = 1'b0;
      tick();

      // Asynchronous reset mid-window with sigin held high across it.
      start(40, 1'b0, k);
      push5('h25, 1'b0, k + 1004);
      run_to(k + 1400);
      per   = 0;
      sigin = 1'b1;
      run_to(k + 1500);
      chk("meas_pre_rst", int'(measuring5), 1);
      @(posedge sysclk);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_bcd5", int'(freq_bcd5), 0);
      chk("arst_valid5", int'(freq_valid5), 0);
      chk("arst_ovf5", int'(overflow5), 0);
      chk("arst_meas5", int'(measuring5), 0);
      repeat (3) tick();
      k   = cyc;
      rst = 1'b0;
      push5('h0, 1'b0, k + 1004);
      run_to(k + 1010);
      en5 = 1'b0;

      repeat (5) tick();
      chk("q5_drained", q5.size(), 0);
      chk("q2_drained", q2.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
